// File: rtl/hamming_pkg.sv
// Shared constants and types for the Hamming(7,4) block decoder.
package hamming_pkg;

    localparam int N = 7;
    localparam int K = 4;

    // Each mask selects the codeword bits that feed one syndrome bit.
    localparam logic [N-1:0] SYN_MASK0 = 7'h55;
    localparam logic [N-1:0] SYN_MASK1 = 7'h66;
    localparam logic [N-1:0] SYN_MASK2 = 7'h78;

    // Codeword bit positions of data bits d0..d3 (output nibble is {c6,c5,c4,c2}).
    localparam int DATA_POS [K] = '{2, 4, 5, 6};

    typedef enum logic {
        IDLE   = 1'b0,
        DECODE = 1'b1
    } state_t;

endpackage

// File: rtl/hamming74_correct.sv
// Single-error corrector for one Hamming(7,4) codeword.
module hamming74_correct
    import hamming_pkg::*;
(
    input  logic [N-1:0] cw_i,
    output logic [K-1:0] data_o,
    output logic         corrected_o
);

    logic [2:0]   syn;
    logic [N-1:0] flip;
    logic [N-1:0] fixed;

    // Syndrome points at the erroneous position (1-based); zero means clean.
    always_comb begin
        syn   = {^(cw_i & SYN_MASK2), ^(cw_i & SYN_MASK1), ^(cw_i & SYN_MASK0)};
        flip  = '0;
        if (syn != 3'd0) flip[syn - 3'd1] = 1'b1;
        fixed = cw_i ^ flip;
        for (int i = 0; i < K; i++) data_o[i] = fixed[DATA_POS[i]];
        corrected_o = (syn != 3'd0);
    end

endmodule

// File: rtl/hamming_block_decoder.sv
// Block decoder: latches one block of codewords and corrects them one per clock
// through a single shared corrector, then presents payload and correction count.
module hamming_block_decoder
    import hamming_pkg::*;
#(
    parameter int n          = 7,
    parameter int k          = 4,
    parameter int symbol_num = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            r_en,
    input  logic [n*symbol_num-1:0]         r_data_i,
    output logic                            in_ready,
    output logic                            r_eno,
    output logic [k*symbol_num-1:0]         r_data_o,
    output logic [$clog2(symbol_num+1)-1:0] err_cnt
);

    localparam int IDX_W = (symbol_num > 1) ? $clog2(symbol_num) : 1;
    localparam int ERR_W = $clog2(symbol_num + 1);

    state_t                         state_q;
    logic [symbol_num-1:0][n-1:0]   blk_q;
    logic [symbol_num-1:0][k-1:0]   acc_q, acc_d;
    logic [ERR_W-1:0]               err_acc_q, err_acc_d;
    logic [IDX_W-1:0]               idx_q;
    logic                           in_ready_q, r_eno_q;
    logic [k*symbol_num-1:0]        r_data_o_q;
    logic [ERR_W-1:0]               err_cnt_q;

    logic [N-1:0] cw;
    logic [K-1:0] nib;
    logic         corr;

    assign cw = blk_q[idx_q];

    hamming74_correct u_corr (
        .cw_i        (cw),
        .data_o      (nib),
        .corrected_o (corr)
    );

    // Merge the current codeword's result into the running accumulators.
    always_comb begin
        acc_d        = acc_q;
        acc_d[idx_q] = nib;
        err_acc_d    = err_acc_q + ERR_W'(corr);
    end

    // Control FSM; completion loads the outputs and returns to IDLE in one step,
    // so a new block can be accepted during the r_eno cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            blk_q      <= '0;
            acc_q      <= '0;
            err_acc_q  <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b1;
            r_eno_q    <= 1'b0;
            r_data_o_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            r_eno_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (r_en) begin
                        blk_q      <= r_data_i;
                        idx_q      <= '0;
                        acc_q      <= '0;
                        err_acc_q  <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= DECODE;
                    end
                end
                DECODE: begin
                    acc_q     <= acc_d;
                    err_acc_q <= err_acc_d;
                    if (idx_q == IDX_W'(symbol_num - 1)) begin
                        r_data_o_q <= acc_d;
                        err_cnt_q  <= err_acc_d;
                        r_eno_q    <= 1'b1;
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign r_eno    = r_eno_q;
    assign r_data_o = r_data_o_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_hamming_block_decoder.sv
// Scoreboard bench for hamming_block_decoder: the driver pushes expected results,
// a negedge monitor pops and compares them whenever r_eno is seen.
module tb_hamming_block_decoder;

    logic        clk;
    logic        rst;
    logic        r_en;
    logic [27:0] r_data_i;
    logic        in_ready;
    logic        r_eno;
    logic [15:0] r_data_o;
    logic [2:0]  err_cnt;

    hamming_block_decoder dut (
        .clk      (clk),
        .rst      (rst),
        .r_en     (r_en),
        .r_data_i (r_data_i),
        .in_ready (in_ready),
        .r_eno    (r_eno),
        .r_data_o (r_data_o),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [2:0]  e;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    localparam logic [27:0] GARBAGE = 28'hFFFFFFF;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every r_eno must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (r_eno === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_r_eno: got pulse, expected none (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("r_data_o", 32'(r_data_o), 32'(e.d));
                chk("err_cnt", 32'(err_cnt), 32'(e.e));
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Reference encoder for one data nibble.
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] c;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[3] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

    // Waits for in_ready (keeping r_en as is, presenting garbage meanwhile), then offers blk.
    task automatic issue(input logic [27:0] blk, input logic [15:0] d, input logic [2:0] e,
                         input bit push);
        int n;
        exp_t x;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            r_data_i = GARBAGE;
            n++;
            if (n > 20) begin
                checks++;
                failures++;
                $display("FAIL in_ready_timeout: got 0, expected 1");
                break;
            end
        end
        r_en     = 1'b1;
        r_data_i = blk;
        if (push) begin
            x.d   = d;
            x.e   = e;
            x.cyc = cyc + 5;
            exp_q.push_back(x);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [27:0] blk;
        logic [15:0] dat;
        logic [2:0]  ne;
        logic [6:0]  cw;
        logic [3:0]  nibv;

        rst = 1'b1; r_en = 1'b0; r_data_i = '0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_r_eno", 32'(r_eno), 32'd0);
        chk("rst_r_data_o", 32'(r_data_o), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed single blocks.
        issue(28'hAB56AD5, 16'hBBBB, 3'd0, 1'b1);
        @(negedge clk) r_en = 1'b0;
        drain();
        issue(28'hAB56AD5 ^ (28'd1 << 18), 16'hBBBB, 3'd1, 1'b1);
        @(negedge clk) r_en = 1'b0;
        drain();
        issue(28'h0204081, 16'h0000, 3'd4, 1'b1);
        @(negedge clk) r_en = 1'b0;
        drain();

        // Back-to-back with r_en held high; mid-DECODE data is garbage and must be ignored.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) issue(28'h0, 16'h0000, 3'd0, 1'b1);
            else            issue(28'hAB56AD5, 16'hBBBB, 3'd0, 1'b1);
        end
        @(negedge clk) r_en = 1'b0;
        drain();

        // Reset during the second DECODE cycle: result discarded, outputs cleared.
        issue(28'h0204081, 16'h0000, 3'd4, 1'b0);
        @(negedge clk) r_en = 1'b0;
        @(negedge clk) rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_r_eno", 32'(r_eno), 32'd0);
        chk("midrst_r_data_o", 32'(r_data_o), 32'd0);
        chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (6) @(negedge clk);
        issue(28'hAB56AD5 ^ (28'd1 << 3), 16'hBBBB, 3'd1, 1'b1);
        @(negedge clk) r_en = 1'b0;
        drain();

        // Random blocks: 0 or 1 flip per codeword against the reference encoder.
        for (int b = 0; b < 60; b++) begin
            ne = 3'd0;
            for (int j = 0; j < 4; j++) begin
                nibv = 4'($urandom_range(0, 15));
                cw   = enc(nibv);
                if ($urandom_range(0, 1) == 1) begin
                    cw[$urandom_range(0, 6)] ^= 1'b1;
                    ne++;
                end
                blk[7*j +: 7] = cw;
                dat[4*j +: 4] = nibv;
            end
            issue(blk, dat, ne, 1'b1);
        end
        @(negedge clk) r_en = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
